// File: rtl/pll_phase_ctrl.sv
// PLL dynamic phase-shift controller.
// Accepts a command (target output, direction, step count or load request),
// drives the PLL PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG pins with timed
// active-low pulses, then waits for the PLL to report lock again.
// Per-output phase positions are tracked modulo PHASE_MOD.
module pll_phase_ctrl #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 4,
  parameter int GAP_CYC      = 4,
  parameter int LOCK_TIMEOUT = 1023,
  parameter int PHASE_MOD    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic        req_dir,
  input  logic [7:0]  req_steps,
  input  logic        req_load,
  input  logic        pll_locked,
  output logic [1:0]  phasesel,
  output logic        phasedir,
  output logic        phasestep,
  output logic        phaseloadreg,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] phase_pos
);

  // One shared down-the-state counter; sized for the longest interval.
  localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CD  = (GAP_CYC > LOCK_TIMEOUT) ? GAP_CYC : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       POS_MASK     = 4'(PHASE_MOD - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_PULSE     = 3'd2,
    S_GAP       = 3'd3,
    S_WAIT_LOCK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       steps_q, steps_d;
  logic             load_q, load_d;
  logic [1:0]       sel_q, sel_d;
  logic             dir_q, dir_d;
  logic [15:0]      pos_q, pos_d;
  logic [1:0]       sync_q;
  logic             lock_s;
  logic             step_n_q, step_n_d;
  logic             loadreg_n_q, loadreg_n_d;
  logic             busy_q, busy_d;
  logic             req_ready_q, req_ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // One step of a phase position, wrapping within the power-of-two modulus.
  function automatic logic [3:0] step_pos(input logic [3:0] pos, input logic dir);
    logic [3:0] nxt;
    nxt = dir ? (pos - 4'd1) : (pos + 4'd1);
    return nxt & POS_MASK;
  endfunction

  assign lock_s = sync_q[1];

  // Two-flop synchroniser bringing the asynchronous PLL lock into clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  // Sequencer next state, interval counter, command capture and positions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    load_d  = load_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          load_d  = req_load;
          cnt_d   = '0;
          if (!req_load && (req_steps == 8'd0)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SETUP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d = '0;
          if (load_q) begin
            pos_d[{sel_q, 2'b00} +: 4] = 4'd0;
            state_d = S_WAIT_LOCK;
          end else begin
            pos_d[{sel_q, 2'b00} +: 4] = step_pos(pos_q[{sel_q, 2'b00} +: 4], dir_q);
            steps_d = steps_q - 8'd1;
            if (steps_q > 8'd1) begin
              state_d = S_GAP;
            end else begin
              state_d = S_WAIT_LOCK;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    // Pin levels follow the upcoming state so every output leaves a flop.
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE);
    step_n_d    = !((state_d == S_PULSE) && !load_d);
    loadreg_n_d = !((state_d == S_PULSE) && load_d);
  end

  // State and output registers; reset releases both PLL pulse pins at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      steps_q     <= 8'd0;
      load_q      <= 1'b0;
      sel_q       <= 2'd0;
      dir_q       <= 1'b1;
      pos_q       <= 16'd0;
      step_n_q    <= 1'b1;
      loadreg_n_q <= 1'b1;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      steps_q     <= steps_d;
      load_q      <= load_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
      step_n_q    <= step_n_d;
      loadreg_n_q <= loadreg_n_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_n_q;
  assign phaseloadreg = loadreg_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign phase_pos    = pos_q;

endmodule
